// File: rtl/cv_bus_term_array_reg.sv
// cv_bus_term_array_reg
//   NCH channels, each reducing a WIN-bit bus slice to one bit with a
//   runtime-selectable function (OR / AND / XOR / bit 0). Reduced words are
//   queued in a 2-entry registered FIFO with valid/ready handshakes. A
//   saturating per-channel toggle counter tracks result-bit changes across
//   accepted words.
//
// Ports
//   clk, rstb     clock (rising edge), asynchronous active-low reset
//   mode[1:0]     reduction select, sampled on accept
//                 00 OR, 01 AND, 10 XOR, 11 bit 0
//   in_valid      input word valid
//   in_ready      block can accept a word (FIFO not full)
//   in_data       channel c at [c*WIN +: WIN]
//   out_valid     FIFO head valid
//   out_ready     consumer accepts head
//   out_data      head word (bit c = channel c), 0 when empty
//   clr_cnt       synchronous clear of all toggle counters
//   toggle_cnt    counter c at [c*CNT_W +: CNT_W]
module cv_bus_term_array_reg #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned WIN   = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic [1:0]             mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NCH*WIN-1:0]     in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NCH-1:0]         out_data,
  input  logic                   clr_cnt,
  output logic [NCH*CNT_W-1:0]   toggle_cnt
);

  localparam logic [1:0] MODE_OR  = 2'b00;
  localparam logic [1:0] MODE_AND = 2'b01;
  localparam logic [1:0] MODE_XOR = 2'b10;

  typedef enum logic [1:0] {
    FILL_EMPTY = 2'd0,
    FILL_ONE   = 2'd1,
    FILL_FULL  = 2'd2
  } fill_e;

  fill_e          fill_q, fill_d;
  logic [NCH-1:0] head_q, head_d;
  logic [NCH-1:0] tail_q, tail_d;
  logic           in_ready_q, out_valid_q;
  logic [NCH-1:0] word_c;
  logic           push_c, pop_c;

  // Handshakes use only registered flags, so there is no comb path in->out.
  assign push_c = in_valid & in_ready_q;
  assign pop_c  = out_valid_q & out_ready;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = head_q;

  // Per-channel reduction and toggle tracking.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [WIN-1:0]   bus;
    logic             last_q;
    logic [CNT_W-1:0] cnt_q;

    assign bus = in_data[c*WIN +: WIN];

    assign word_c[c] = (mode == MODE_OR)  ? (|bus) :
                       (mode == MODE_AND) ? (&bus) :
                       (mode == MODE_XOR) ? (^bus) :
                                            bus[0];

    // Clear wins over a coincident increment; last is tracked regardless.
    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        last_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        if (push_c) begin
          last_q <= word_c[c];
        end
        if (clr_cnt) begin
          cnt_q <= '0;
        end else if (push_c && (word_c[c] != last_q) && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end

    assign toggle_cnt[c*CNT_W +: CNT_W] = cnt_q;
  end

  // FIFO state register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      fill_q      <= FILL_EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      fill_q      <= fill_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      in_ready_q  <= (fill_d != FILL_FULL);
      out_valid_q <= (fill_d != FILL_EMPTY);
    end
  end

  // FIFO next state; head slot is zeroed when it empties so out_data reads 0.
  always_comb begin
    fill_d = fill_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case (fill_q)
      FILL_EMPTY: begin
        if (push_c) begin
          head_d = word_c;
          fill_d = FILL_ONE;
        end
      end
      FILL_ONE: begin
        if (push_c && pop_c) begin
          head_d = word_c;
        end else if (push_c) begin
          tail_d = word_c;
          fill_d = FILL_FULL;
        end else if (pop_c) begin
          head_d = '0;
          fill_d = FILL_EMPTY;
        end
      end
      FILL_FULL: begin
        if (pop_c) begin
          head_d = tail_q;
          tail_d = '0;
          fill_d = FILL_ONE;
        end
      end
      default: begin
        fill_d = FILL_EMPTY;
        head_d = '0;
        tail_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_cv_bus_term_array_reg.sv
// Testbench for cv_bus_term_array_reg: directed scenarios plus randomized
// traffic, all checked against a queue-based behavioural model.
module tb_cv_bus_term_array_reg;

  localparam int unsigned NCH   = 2;
  localparam int unsigned WIN   = 2;
  localparam int unsigned CNT_W = 2;

  logic                 clk;
  logic                 rstb;
  logic [1:0]           mode;
  logic                 in_valid;
  logic                 in_ready;
  logic [NCH*WIN-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [NCH-1:0]       out_data;
  logic                 clr_cnt;
  logic [NCH*CNT_W-1:0] toggle_cnt;

  cv_bus_term_array_reg #(.NCH(NCH), .WIN(WIN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .clr_cnt    (clr_cnt),
    .toggle_cnt (toggle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int m_q[$];
  int m_last[NCH];
  int m_cnt[NCH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reduction straight from the mode table, using plain arithmetic.
  function automatic int reduce(input int data, input int md);
    int res = 0;
    for (int c = 0; c < NCH; c++) begin
      int bus = (data >> (c * WIN)) % (1 << WIN);
      int b;
      case (md)
        0:       b = (bus != 0) ? 1 : 0;
        1:       b = (bus == (1 << WIN) - 1) ? 1 : 0;
        2:       b = $countones(bus) % 2;
        default: b = bus % 2;
      endcase
      res |= b << c;
    end
    return res;
  endfunction

  task automatic model_reset();
    m_q.delete();
    for (int c = 0; c < NCH; c++) begin
      m_last[c] = 0;
      m_cnt[c]  = 0;
    end
  endtask

  // Apply one rising edge worth of behaviour using the inputs now driven.
  task automatic model_step();
    int  w   = reduce(int'(in_data), int'(mode));
    bit  acc = in_valid && (m_q.size() < 2);
    bit  pp  = out_ready && (m_q.size() > 0);
    int  sat = (1 << CNT_W) - 1;
    if (pp) void'(m_q.pop_front());
    if (acc) m_q.push_back(w);
    for (int c = 0; c < NCH; c++) begin
      int b = (w >> c) & 1;
      if (clr_cnt) m_cnt[c] = 0;
      else if (acc && b != m_last[c]) m_cnt[c] = (m_cnt[c] < sat) ? m_cnt[c] + 1 : sat;
      if (acc) m_last[c] = b;
    end
  endtask

  task automatic check_outputs();
    int e_tog = 0;
    for (int c = 0; c < NCH; c++) e_tog |= m_cnt[c] << (c * CNT_W);
    chk("in_ready",   32'(in_ready),   32'((m_q.size() < 2) ? 1 : 0));
    chk("out_valid",  32'(out_valid),  32'((m_q.size() > 0) ? 1 : 0));
    chk("out_data",   32'(out_data),   32'((m_q.size() > 0) ? m_q[0] : 0));
    chk("toggle_cnt", 32'(toggle_cnt), 32'(e_tog));
  endtask

  // Called at a falling edge: check, take one rising edge, return at next falling edge.
  task automatic cycle();
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Asynchronous reset pulse placed between edges, with immediate output check.
  task automatic async_reset();
    #2;
    rstb     = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    clr_cnt  = 1'b0;
    #1;
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_out_data",   32'(out_data),   32'd0);
    chk("rst_in_ready",   32'(in_ready),   32'd1);
    chk("rst_toggle_cnt", 32'(toggle_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    rstb = 1'b1;
  endtask

  task automatic single_word_after_reset();
    mode = 2'b00; in_data = 4'b0100; in_valid = 1'b1; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    chk("s1_out_data",  32'(out_data),   32'h2);
    chk("s1_out_valid", 32'(out_valid),  32'd1);
    chk("s1_toggle",    32'(toggle_cnt), 32'h4);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    cycle();
  endtask

  logic [1:0] exp_mode[4];

  initial begin
    exp_mode[0] = 2'b11; exp_mode[1] = 2'b10; exp_mode[2] = 2'b01; exp_mode[3] = 2'b11;
    rstb = 1'b0; mode = 2'b00; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_cnt = 1'b0;
    model_reset();
    #12;
    chk("init_out_valid", 32'(out_valid),  32'd0);
    chk("init_in_ready",  32'(in_ready),   32'd1);
    chk("init_toggle",    32'(toggle_cnt), 32'd0);
    @(negedge clk);
    rstb = 1'b1;

    // Scenario 1: first word after reset
    single_word_after_reset();

    // Scenario 2: each reduction mode on 4'b1101
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m); in_data = 4'b1101; in_valid = 1'b1; out_ready = 1'b0;
      cycle();
      in_valid = 1'b0;
      chk($sformatf("s2_mode%0d", m), 32'(out_data), 32'(exp_mode[m]));
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
    end

    // Scenario 3: backpressure
    mode = 2'b00; out_ready = 1'b0; in_valid = 1'b1;
    in_data = 4'b0011; cycle();
    in_data = 4'b1100; cycle();
    chk("s3_full_ready", 32'(in_ready), 32'd0);
    in_data = 4'b1111; cycle();
    out_ready = 1'b1;
    chk("s3_head_a", 32'(out_data), 32'h1);
    cycle();
    out_ready = 1'b0;
    chk("s3_ready_back", 32'(in_ready), 32'd1);
    cycle();
    in_valid = 1'b0; out_ready = 1'b1;
    chk("s3_head_b", 32'(out_data), 32'h2);
    cycle();
    chk("s3_head_c", 32'(out_data), 32'h3);
    cycle();
    cycle();

    // Scenario 4: streaming at occupancy 1
    out_ready = 1'b1; in_valid = 1'b1; in_data = 4'b0000;
    cycle();
    for (int i = 0; i < 10; i++) begin
      in_data = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      chk("s4_in_ready",  32'(in_ready),  32'd1);
      chk("s4_out_valid", 32'(out_valid), 32'd1);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    cycle();

    // Scenario 5: saturation and clear
    async_reset();
    mode = 2'b00; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      cycle();
    end
    chk("s5_saturated", 32'(toggle_cnt[1:0]), 32'd3);
    in_data = 4'b0000; clr_cnt = 1'b1;
    cycle();
    clr_cnt = 1'b0;
    chk("s5_cleared", 32'(toggle_cnt[1:0]), 32'd0);
    in_data = 4'b0001;
    cycle();
    chk("s5_after_clr", 32'(toggle_cnt[1:0]), 32'd1);
    in_valid = 1'b0;
    cycle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = 4'($urandom);
      mode      = 2'($urandom);
      out_ready = ($urandom % 3) != 0;
      clr_cnt   = ($urandom % 16) == 0;
      cycle();
    end
    in_valid = 1'b0; clr_cnt = 1'b0; out_ready = 1'b0;

    // Scenario 6: reset while full
    in_valid = 1'b1; in_data = 4'b1111; mode = 2'b00;
    cycle();
    cycle();
    chk("s6_full", 32'(in_ready), 32'd0);
    async_reset();
    single_word_after_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cv_bus_term_array_reg.md
Name: cv_bus_term_array_reg

Overview:
Parametrised, clocked successor to the two-channel bus-terminator array. It holds NCH channels, and each channel reduces a WIN-bit input bus to one output bit. The reduction function is runtime-selectable. Results pass through a 2-entry output FIFO with valid/ready handshakes, and a saturating per-channel toggle counter sits alongside the data path. The block sits between bused stimulus sources and single-bit consumers in test harnesses and digital wrappers.

Parameters:
- NCH, 2, number of channels (>=1)
- WIN, 2, input bus width per channel (>=1)
- CNT_W, 8, width of each per-channel toggle counter (>=1)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rstb  input  1  asynchronous active-low reset
- mode  input  2  reduction select, sampled on input acceptance: 00 OR, 01 AND, 10 XOR, 11 pass bit 0 of the channel bus
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept a word
- in_data  input  NCH*WIN  channel c occupies bits [c*WIN +: WIN]
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accepts head
- out_data  output  NCH  bit c is the channel c result
- clr_cnt  input  1  synchronous clear of all toggle counters
- toggle_cnt  output  NCH*CNT_W  counter c occupies bits [c*CNT_W +: CNT_W]

Behaviour:
- Reset (rstb=0, asynchronous, held until release): FIFO empty, out_valid=0, out_data=0, in_ready=1, all toggle_cnt=0, all per-channel last-result bits=0.
- Accept (push) when in_valid & in_ready at a rising edge.
  - The reduced NCH-bit word is computed combinationally from in_data and the current mode.
  - That word is written to the FIFO tail.
- Pop when out_valid & out_ready at a rising edge; the head advances.
- FIFO storage and flags:
  - Depth 2, registered storage, no combinational bypass.
  - in_ready = !full.
  - out_valid = !empty.
  - out_data = head entry when valid, 0 when empty.
- Latency: a word accepted at edge N gives out_valid=1 with that data after edge N, provided the FIFO was empty.
- Simultaneous push and pop:
  - One entry: both occur; occupancy stays 1; the new word becomes head after the old head pops.
  - Full: push is blocked because in_ready=0; pop occurs; in_ready rises the next cycle.
  - Empty: pop cannot occur; push proceeds.
- Holding: out_data and out_valid stay stable while out_valid=1 and out_ready=0.
- Mode: changes take effect only on accepted words; words already in the FIFO are unaffected.
- Mode 11 with WIN=1 is identical to OR/AND/XOR. Modes 00-10 with WIN=1 pass the single bit.
- Toggle counters, per channel c on each accept:
  - If the result bit differs from last[c], counter c increments; it saturates at 2^CNT_W-1 and never wraps.
  - last[c] updates to the result bit on every accept.
- clr_cnt=1 zeroes all counters in that cycle and overrides a coincident increment (result is 0, not 1). clr_cnt does not modify last[] or the FIFO.
- Reset mid-operation: all FIFO contents are discarded immediately, and the outputs return to their reset values asynchronously.

Test Plan:
1. Reset and mode-0 single word. Hold rstb=0, then release. Check out_valid=0, in_ready=1, toggle_cnt=0. With NCH=2, WIN=2, mode=00, push in_data=4'b0100. Next cycle out_data=2'b10 and out_valid=1; toggle_cnt channel1=1, channel0=0.
2. Reduction modes on in_data=4'b1101 (ch1=11, ch0=01):
   - mode=00 -> out_data=2'b11
   - mode=01 -> out_data=2'b10
   - mode=10 -> out_data=2'b01
   - mode=11 -> out_data=2'b11
3. Backpressure with out_ready=0. Push A=4'b0011, B=4'b1100, C=4'b1111. A and B are accepted and in_ready=0 after the second accept. C is held until out_ready=1 for one cycle, which pops A (out_data=01). C is accepted the next cycle; the output order is 01, 10, 11.
4. Simultaneous push/pop at occupancy 1 with out_ready=1 and in_valid=1 held for 10 cycles of alternating ch0 data. Check one word out per cycle, in_ready stays 1, and no word is lost or reordered.
5. Saturation and clear with CNT_W=2. Perform 5 accepts toggling ch0 (1,0,1,0,1) -> counter0=3, saturated. Assert clr_cnt coincident with a sixth toggling accept -> counter0=0. The next toggling accept gives counter0=1.
6. Reset mid-operation. With the FIFO full, pulse rstb=0 asynchronously between edges. Check out_valid=0, out_data=0, in_ready=1 immediately and all counters=0; after release, the first push behaves as in scenario 1.
